// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two valid/ready requesters.
// One operation in flight: IDLE (arbitrate/latch) -> EXEC (ALU drive) -> RESP (hold result).
module alu_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH:0]   req0_a,
  input  logic [WIDTH:0]   req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH:0]   req1_a,
  input  logic [WIDTH:0]   req1_b,
  input  logic [3:0]       req1_op,
  output logic [WIDTH:0]   alu_a,
  output logic [WIDTH:0]   alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH+1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH+1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH:0] a;
    logic [WIDTH:0] b;
    logic [3:0]     op;
  } op_t;

  typedef struct packed {
    logic             id;
    logic [WIDTH+1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
  } rsp_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   id_q, id_d;
  op_t    op_q, op_d;
  rsp_t   rsp_q, rsp_d;
  logic   rsp_valid_q, rsp_valid_d;
  logic   grant0, grant1;

  // last_grant==1 means port 0 has priority on the next contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = req0_valid & (~req1_valid | last_grant_q);
      grant1 = req1_valid & ~grant0;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    rsp_d        = rsp_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          op_d         = grant1 ? '{a: req1_a, b: req1_b, op: req1_op}
                                : '{a: req0_a, b: req0_b, op: req0_op};
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_d       = '{id: id_q, result: alu_result, zero: alu_zero,
                        carry: alu_carry, overflow: alu_overflow};
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      rsp_q        <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      rsp_q        <= rsp_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign alu_a        = op_q.a;
  assign alu_b        = op_q.b;
  assign alu_control  = op_q.op;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_q.id;
  assign rsp_result   = rsp_q.result;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_carry    = rsp_q.carry;
  assign rsp_overflow = rsp_q.overflow;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table vectors, hand sequences for corner cases,
// and random traffic checked every cycle against a transaction-level model.
module tb_alu_share_arbiter;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W:0]   req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic [W:0]   alu_a, alu_b;
  logic [3:0]   alu_control;
  logic [W+1:0] alu_result;
  logic         alu_zero, alu_carry, alu_overflow;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W+1:0] rsp_result;
  logic         rsp_zero, rsp_carry, rsp_overflow;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow)
  );

  typedef struct packed { logic [W+1:0] res; logic z; logic c; logic v; } alu_out_t;

  // Environment ALU: AND, OR, ADD, SUB; every other code returns 0.
  function automatic alu_out_t alu_fn(logic [W:0] a, logic [W:0] b, logic [3:0] op);
    alu_out_t   o;
    logic [W:0] x;
    logic [W+1:0] u;
    o = '0;
    case (op)
      4'b0000: begin x = a & b; o.res = {x[W], x}; end
      4'b0001: begin x = a | b; o.res = {x[W], x}; end
      4'b0010: begin
        o.res = {a[W], a} + {b[W], b};
        u = {1'b0, a} + {1'b0, b};
        o.c = u[W+1];
        o.v = (a[W] == b[W]) && (u[W] != a[W]);
      end
      4'b0101: begin
        o.res = {a[W], a} - {b[W], b};
        u = {1'b0, a} + {1'b0, ~b} + (W+2)'(1);
        o.c = u[W+1];
        o.v = (a[W] != b[W]) && (u[W] != a[W]);
      end
      default: o.res = '0;
    endcase
    o.z = (o.res == '0);
    return o;
  endfunction

  alu_out_t alu_o;
  assign alu_o        = alu_fn(alu_a, alu_b, alu_control);
  assign alu_result   = alu_o.res;
  assign alu_zero     = alu_o.z;
  assign alu_carry    = alu_o.c;
  assign alu_overflow = alu_o.v;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- transaction-level reference model ----------------
  typedef struct { logic id; logic [W:0] a; logic [W:0] b; logic [3:0] op; alu_out_t o; } exp_t;
  exp_t       m_q[$];
  logic       m_exec, m_rspv, m_last;
  logic [W:0] m_la, m_lb;
  logic [3:0] m_lop;

  initial begin
    logic  free, g0, g1;
    exp_t  e;
    m_exec = 1'b0; m_rspv = 1'b0; m_last = 1'b1; m_la = '0; m_lb = '0; m_lop = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_exec = 1'b0; m_rspv = 1'b0; m_last = 1'b1; m_la = '0; m_lb = '0; m_lop = '0;
        m_q.delete();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_fields", 32'({rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow}), 32'(0));
        chk("rst_alu_drive", 32'({alu_a, alu_b, alu_control}), 32'(0));
      end else begin
        free = !m_exec && !m_rspv;
        g0 = free && req0_valid && (!req1_valid || m_last);
        g1 = free && req1_valid && !g0;
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rspv));
        chk("alu_drive", 32'({alu_a, alu_b, alu_control}), 32'({m_la, m_lb, m_lop}));
        if (m_rspv && m_q.size() > 0) begin
          chk("rsp_id", 32'(rsp_id), 32'(m_q[0].id));
          chk("rsp_result", 32'(rsp_result), 32'(m_q[0].o.res));
          chk("rsp_flags", 32'({rsp_zero, rsp_carry, rsp_overflow}),
              32'({m_q[0].o.z, m_q[0].o.c, m_q[0].o.v}));
        end
        if (m_rspv && rsp_ready) begin
          if (m_q.size() > 0) void'(m_q.pop_front());
          m_rspv = 1'b0;
        end
        if (m_exec) begin
          m_exec = 1'b0;
          m_rspv = 1'b1;
        end
        if (g0 || g1) begin
          e.id = g1;
          e.a  = g1 ? req1_a  : req0_a;
          e.b  = g1 ? req1_b  : req0_b;
          e.op = g1 ? req1_op : req0_op;
          e.o  = alu_fn(e.a, e.b, e.op);
          m_q.push_back(e);
          m_exec = 1'b1;
          m_last = g1;
          m_la = e.a; m_lb = e.b; m_lop = e.op;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct { logic id; logic [W+1:0] res; logic z; logic c; logic v; } rsp_t;
  typedef struct { logic id; int cyc; } grant_t;
  rsp_t   rlog[$];
  grant_t glog[$];

  function automatic logic [3:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 4'b0010;
      1:       return 4'b0101;
      2:       return 4'($urandom_range(0, 1));
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // mode 0: drop valid after accept; 1: keep valid with new operands; 2: random traffic
  task automatic run_cycle(int mode);
    logic   a0, a1;
    rsp_t   r;
    grant_t g;
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    if (rsp_valid && rsp_ready) begin
      r.id = rsp_id; r.res = rsp_result; r.z = rsp_zero; r.c = rsp_carry; r.v = rsp_overflow;
      rlog.push_back(r);
    end
    if (a0 || a1) begin
      g.id = a1; g.cyc = cyc;
      glog.push_back(g);
    end
    @(posedge clk);
    #1;
    if (mode == 0) begin
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end else if (mode == 1) begin
      if (a0) begin req0_a = 5'($urandom); req0_b = 5'($urandom); req0_op = rand_op(); end
      if (a1) begin req1_a = 5'($urandom); req1_b = 5'($urandom); req1_op = rand_op(); end
    end else begin
      if (!req0_valid || a0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_a = 5'($urandom); req0_b = 5'($urandom); req0_op = rand_op();
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_a = 5'($urandom); req1_b = 5'($urandom); req1_op = rand_op();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_rsp(int n, string nm);
    int k = 0;
    while (rlog.size() < n && k < 40) begin
      run_cycle(0);
      k++;
    end
    chk(nm, 32'(rlog.size()), 32'(n));
  endtask

  typedef struct {
    logic port; logic [W:0] a; logic [W:0] b; logic [3:0] op;
    logic [W+1:0] res; logic z; logic c; logic v;
  } vec_t;
  vec_t vt[8];

  // ---------------- main sequence ----------------
  initial begin
    int n, n0, k;
    vt[0] = '{1'b0, 5'd3,      5'd5,      4'b0000, 6'h01, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 5'd3,      5'd4,      4'b0010, 6'h07, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 5'd9,      5'd2,      4'b0101, 6'h07, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b1, 5'd5,      5'd5,      4'b1111, 6'h00, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 5'd15,     5'd1,      4'b0010, 6'h10, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 5'd0,      5'd1,      4'b0101, 6'h3F, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 5'b10000,  5'd1,      4'b0001, 6'h31, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b1, 5'b10000,  5'b10000,  4'b0010, 6'h20, 1'b0, 1'b1, 1'b1};

    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_alu_a", 32'(alu_a), 32'(0));
    chk("reset_alu_control", 32'(alu_control), 32'(0));

    // contention straight out of reset: port 0 first
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1; req0_a = 5'd3; req0_b = 5'd4; req0_op = 4'b0010;
    req1_valid = 1; req1_a = 5'd9; req1_b = 5'd2; req1_op = 4'b0101;
    wait_rsp(2, "contend_count");
    if (rlog.size() >= 2) begin
      chk("contend_first_id", 32'(rlog[0].id), 32'(0));
      chk("contend_first_res", 32'(rlog[0].res), 32'(7));
      chk("contend_second_id", 32'(rlog[1].id), 32'(1));
      chk("contend_second_res", 32'(rlog[1].res), 32'(7));
    end

    // table of single operations
    for (int i = 0; i < 8; i++) begin
      n = rlog.size();
      if (vt[i].port) begin
        req1_valid = 1; req1_a = vt[i].a; req1_b = vt[i].b; req1_op = vt[i].op;
      end else begin
        req0_valid = 1; req0_a = vt[i].a; req0_b = vt[i].b; req0_op = vt[i].op;
      end
      wait_rsp(n + 1, "vec_count");
      if (rlog.size() > n) begin
        chk($sformatf("vec%0d_id", i), 32'(rlog[n].id), 32'(vt[i].port));
        chk($sformatf("vec%0d_res", i), 32'(rlog[n].res), 32'(vt[i].res));
        chk($sformatf("vec%0d_flags", i), 32'({rlog[n].z, rlog[n].c, rlog[n].v}),
            32'({vt[i].z, vt[i].c, vt[i].v}));
      end
    end

    // backpressure: response held for 5 cycles, then release
    run_cycle(0);
    rsp_ready = 1'b0;
    req0_valid = 1; req0_a = 5'd2; req0_b = 5'd3; req0_op = 4'b0010;
    k = 0;
    while (!rsp_valid && k < 10) begin
      run_cycle(0);
      if (!req0_valid) req1_valid = 1'b1;
      k++;
    end
    req1_a = 5'd1; req1_b = 5'd1; req1_op = 4'b0000;
    chk("bp_rsp_seen", 32'(rsp_valid), 32'(1));
    for (int i = 0; i < 5; i++) begin
      run_cycle(0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'(1));
      chk("bp_hold_result", 32'(rsp_result), 32'(5));
      chk("bp_hold_id", 32'(rsp_id), 32'(0));
      chk("bp_hold_flags", 32'({rsp_zero, rsp_carry, rsp_overflow}), 32'(0));
      chk("bp_hold_ready", 32'({req0_ready, req1_ready}), 32'(0));
    end
    rsp_ready = 1'b1;
    n0 = glog.size();
    run_cycle(0);
    chk("bp_release_valid", 32'(rsp_valid), 32'(0));
    chk("bp_release_grant", 32'(req1_ready), 32'(1));
    run_cycle(0);
    chk("bp_new_grant", 32'(glog.size()), 32'(n0 + 1));
    wait_rsp(rlog.size() + 1, "bp_drain");

    // reset during EXEC with req1 pending
    req0_valid = 1; req0_a = 5'd1; req0_b = 5'd1; req0_op = 4'b0010;
    n0 = glog.size();
    k = 0;
    while (glog.size() == n0 && k < 10) begin run_cycle(0); k++; end
    chk("rstx_accepted", 32'(glog.size()), 32'(n0 + 1));
    req1_valid = 1; req1_a = 5'd6; req1_b = 5'd1; req1_op = 4'b0101;
    rst_n = 1'b0;
    #1;
    chk("rstx_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rstx_outputs", 32'({rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow}), 32'(0));
    chk("rstx_alu", 32'({alu_a, alu_b, alu_control}), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1; req0_a = 5'd4; req0_b = 5'd2; req0_op = 4'b0101;
    n0 = glog.size();
    n = rlog.size();
    rst_n = 1'b1;
    repeat (20) run_cycle(1);
    chk("alt_count", 32'(glog.size() >= n0 + 6), 32'(1));
    if (glog.size() >= n0 + 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("alt_id%0d", i), 32'(glog[n0 + i].id), 32'(i % 2));
        if (i > 0) chk($sformatf("alt_gap%0d", i), 32'(glog[n0 + i].cyc - glog[n0 + i - 1].cyc), 32'(3));
      end
    end
    chk("alt_no_stale_rsp", 32'(rlog.size() > n), 32'(1));
    req0_valid = 0; req1_valid = 0;
    repeat (6) run_cycle(0);

    // random traffic; the model checks every cycle
    repeat (600) run_cycle(2);
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (8) run_cycle(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
